// File: rtl/seq_divider.sv
// Sequential restoring divider (DIV/DIVU/REM/REMU) with a single-cycle result pulse.
// Define DIV_WORD_OP_EN to add the 32-bit W-variant operations selected by div_word.
module seq_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic        div_signed,
    input  logic        div_word,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    input  logic        flush,
    output logic        out_valid,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [63:0] r_quo, r_rem, r_bdiv, r_hold_q, r_hold_r;
    logic [5:0]  r_cnt;
    logic        r_neg_q, r_neg_r;

    logic        w_accept, w_a_neg, w_b_neg, w_div_zero, w_ovf, w_special, w_ge;
    logic [63:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_quo_init;
    logic [63:0] w_q_fix, w_r_fix, w_q_res, w_r_res;
    logic [64:0] w_sh, w_diff;
    logic [5:0]  w_cnt_init;

`ifdef DIV_WORD_OP_EN
    logic r_word;

    // Word operands are extended to 64 bits so one magnitude path serves both widths.
    always_comb begin
        w_a_ext    = div_word ? {{32{div_signed & dividend[31]}}, dividend[31:0]} : dividend;
        w_b_ext    = div_word ? {{32{div_signed & divisor[31]}}, divisor[31:0]} : divisor;
        w_min      = div_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        w_cnt_init = div_word ? 6'd31 : 6'd63;
        w_quo_init = div_word ? {w_a_mag[31:0], 32'h0} : w_a_mag;
        w_q_res    = r_word ? {{32{w_q_fix[31]}}, w_q_fix[31:0]} : w_q_fix;
        w_r_res    = r_word ? {{32{w_r_fix[31]}}, w_r_fix[31:0]} : w_r_fix;
    end

    always_ff @(posedge clock) begin
        if (reset)         r_word <= 1'b0;
        else if (w_accept) r_word <= div_word;
    end
`else
    logic w_unused_word;

    assign w_unused_word = div_word;
    assign w_a_ext       = dividend;
    assign w_b_ext       = divisor;
    assign w_min         = 64'h8000_0000_0000_0000;
    assign w_cnt_init    = 6'd63;
    assign w_quo_init    = w_a_mag;
    assign w_q_res       = w_q_fix;
    assign w_r_res       = w_r_fix;
`endif

    assign div_ready  = (r_state == IDLE);
    assign w_accept   = div_valid & div_ready & ~flush;

    assign w_a_neg    = div_signed & w_a_ext[63];
    assign w_b_neg    = div_signed & w_b_ext[63];
    assign w_a_mag    = w_a_neg ? (~w_a_ext + 64'd1) : w_a_ext;
    assign w_b_mag    = w_b_neg ? (~w_b_ext + 64'd1) : w_b_ext;
    assign w_div_zero = (w_b_ext == 64'h0);
    assign w_ovf      = div_signed & (w_a_ext == w_min) & (w_b_ext == '1);
    assign w_special  = w_div_zero | w_ovf;

    assign w_sh       = {r_rem, r_quo[63]};
    assign w_diff     = w_sh - {1'b0, r_bdiv};
    assign w_ge       = ~w_diff[64];

    assign w_q_fix    = r_neg_q ? (~r_quo + 64'd1) : r_quo;
    assign w_r_fix    = r_neg_r ? (~r_rem + 64'd1) : r_rem;

    // A flush in the DONE cycle suppresses the pulse and leaves the outputs untouched.
    assign out_valid  = (r_state == DONE) & ~flush;
    assign quotient   = out_valid ? w_q_res : r_hold_q;
    assign remainder  = out_valid ? w_r_res : r_hold_r;

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : CALC;
            CALC:    if (flush) w_state_nxt = IDLE;
                     else if (r_cnt == 6'd0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_quo    <= 64'h0;
            r_rem    <= 64'h0;
            r_bdiv   <= 64'h0;
            r_cnt    <= 6'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hold_q <= 64'h0;
            r_hold_r <= 64'h0;
        end else begin
            if (w_accept) begin
                r_cnt   <= w_cnt_init;
                r_bdiv  <= w_b_mag;
                r_neg_q <= ~w_special & (w_a_neg ^ w_b_neg);
                r_neg_r <= ~w_special & w_a_neg;
                if (w_div_zero) begin
                    r_quo <= '1;
                    r_rem <= w_a_ext;
                end else if (w_ovf) begin
                    r_quo <= w_a_ext;
                    r_rem <= 64'h0;
                end else begin
                    r_quo <= w_quo_init;
                    r_rem <= 64'h0;
                end
            end else if (r_state == CALC) begin
                r_rem <= w_ge ? w_diff[63:0] : w_sh[63:0];
                r_quo <= {r_quo[62:0], w_ge};
                if (r_cnt != 6'd0) r_cnt <= r_cnt - 6'd1;
            end
            if (out_valid) begin
                r_hold_q <= w_q_res;
                r_hold_r <= w_r_res;
            end
        end
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. Ports SHALL be as listed in REQ-002 to REQ-013, in that order.
REQ-002 clock  in  1  system clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 div_valid  in  1  request strobe; operands and mode inputs are valid.
REQ-005 div_ready  out  1  block accepts a request; equals (state==IDLE).
REQ-006 div_signed  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-007 div_word  in  1  1 = 32-bit W-variant operation.
REQ-008 dividend  in  64  numerator.
REQ-009 divisor  in  64  denominator.
REQ-010 flush  in  1  abort any in-flight operation.
REQ-011 out_valid  out  1  one-cycle pulse; quotient/remainder are valid.
REQ-012 quotient  out  64  result quotient.
REQ-013 remainder  out  64  result remainder.

Function
REQ-014 A request SHALL be accepted in any cycle T where div_valid=1, div_ready=1 and flush=0. Operands and modes SHALL be captured at T.
REQ-015 The FSM SHALL have the states IDLE, CALC and DONE. IDLE->CALC on accept. CALC->DONE after N iterations. DONE->IDLE unconditionally.
REQ-016 N SHALL be 64 for 64-bit operations and 32 for word operations. The block SHALL perform one restoring shift-subtract step per CALC cycle on magnitudes.
REQ-017 For a normal operation, out_valid SHALL pulse in cycle T+N+1 (the DONE cycle).
REQ-018 A zero divisor SHALL go IDLE->DONE, with out_valid at T+1, quotient = all ones (for the active width), and remainder = dividend.
REQ-019 Signed overflow (most-negative / -1) SHALL go IDLE->DONE, with out_valid at T+1, quotient = dividend, and remainder = 0.
REQ-020 Signed results SHALL truncate toward zero. The quotient SHALL be negated when the operand signs differ. The remainder SHALL take the sign of the dividend.
REQ-021 Word operations SHALL use operand bits [31:0] only; in signed mode bit 31 is the operand sign. Both 32-bit results SHALL be sign-extended to 64 bits, including the unsigned word forms.
REQ-022 quotient and remainder SHALL be updated only in the cycle out_valid=1, and SHALL hold their values until the next completion.
REQ-023 There SHALL be no output backpressure: out_valid is a single-cycle pulse and is never repeated.
REQ-024 flush=1 in CALC or DONE SHALL force IDLE on the next edge, with no out_valid pulse; quotient and remainder SHALL keep their prior values.
REQ-025 flush=1 together with div_valid=1 in IDLE SHALL block acceptance; flush SHALL have priority.
REQ-026 div_valid SHALL be ignored while div_ready=0. Operand changes during CALC SHALL NOT affect the result.

Reset
REQ-027 reset=1 SHALL force the following on the next edge: state=IDLE, out_valid=0, quotient=0, remainder=0, iteration counter=0, internal partial remainder and quotient=0.
REQ-028 reset SHALL have priority over flush and accept. Reset mid-CALC SHALL discard the operation without an out_valid pulse.
REQ-029 div_ready SHALL read 1 in the first cycle after reset deasserts.

Configuration
REQ-030 The macro DIV_WORD_OP_EN SHALL control word-operation support.
REQ-031 With DIV_WORD_OP_EN defined, div_word SHALL be honoured as in REQ-016 and REQ-021.
REQ-032 Without DIV_WORD_OP_EN, div_word SHALL be ignored, every operation SHALL be 64-bit with N=64, and the word-path logic SHALL be absent.

Verification
REQ-033 Unsigned 64-bit: dividend=100, divisor=7, accept at T -> out_valid at T+65, quotient=14, remainder=2.
REQ-034 Signed 64-bit: dividend=-7, divisor=2 -> quotient=0xFFFFFFFFFFFFFFFD, remainder=0xFFFFFFFFFFFFFFFF, out_valid at T+65.
REQ-035 Divide by zero: dividend=5, divisor=0 -> out_valid at T+1, quotient=0xFFFFFFFFFFFFFFFF, remainder=5.
REQ-036 Overflow: signed, dividend=0x8000000000000000, divisor=-1 -> out_valid at T+1, quotient=0x8000000000000000, remainder=0.
REQ-037 Word signed, with DIV_WORD_OP_EN: dividend=0x00000000FFFFFFF9, divisor=2 -> out_valid at T+33, quotient=0xFFFFFFFFFFFFFFFD, remainder=0xFFFFFFFFFFFFFFFF.
REQ-038 Flush: flush=1 at T+10 -> no out_valid at any later cycle, div_ready=1 at T+11, and a new request accepted at T+11 completes correctly.
